// File: rtl/id_stage_reg.sv
// ARM decode stage with integrated ID/EX register, bypassed register file,
// condition check against live status, and stall/flush capture control.
// Ports: clk, rst (async active-low); pc_in, instr_in, in_valid, stall, flush,
// status, wb_en/wb_addr/wb_data in; src1_addr, src2_addr, two_src (comb) and
// registered pc_out, control bits, exe_cmd, operands, immediates, dest, status_out.
module id_stage_reg #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 16,
   localparam int AW = ($clog2(NREGS) < 4) ? 4 : $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [31:0]       instr_in,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [3:0]        status,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [AW-1:0]     src1_addr,
   output logic [AW-1:0]     src2_addr,
   output logic              two_src,
   output logic [DATA_W-1:0] pc_out,
   output logic              valid_out,
   output logic              mem_read,
   output logic              mem_write,
   output logic              wb_en_out,
   output logic              branch_taken,
   output logic              status_we,
   output logic [3:0]        exe_cmd,
   output logic [DATA_W-1:0] val_rn,
   output logic [DATA_W-1:0] val_rm,
   output logic              imm,
   output logic [11:0]       shift_operand,
   output logic [23:0]       signed_imm24,
   output logic [AW-1:0]     dest,
   output logic [3:0]        status_out
);

   localparam logic [AW:0] NR = (AW+1)'(NREGS);

   logic [3:0] cond, opcode, rn, rd, rm;
   logic [1:0] mode;
   logic       i_bit, s_bit, is_str;

   assign cond   = instr_in[31:28];
   assign mode   = instr_in[27:26];
   assign i_bit  = instr_in[25];
   assign opcode = instr_in[24:21];
   assign s_bit  = instr_in[20];
   assign rn     = instr_in[19:16];
   assign rd     = instr_in[15:12];
   assign rm     = instr_in[3:0];

   // Stores read Rd as the data to write, so it replaces Rm as source 2.
   assign is_str    = (mode == 2'b01) & ~s_bit;
   assign src1_addr = AW'(rn);
   assign src2_addr = is_str ? AW'(rd) : AW'(rm);
   assign two_src   = in_valid & (((mode == 2'b00) & ~i_bit) | is_str);

   logic n_f, z_f, c_f, v_f, cond_ok;
   assign {n_f, z_f, c_f, v_f} = status;

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         4'h0: cond_ok = z_f;
         4'h1: cond_ok = ~z_f;
         4'h2: cond_ok = c_f;
         4'h3: cond_ok = ~c_f;
         4'h4: cond_ok = n_f;
         4'h5: cond_ok = ~n_f;
         4'h6: cond_ok = v_f;
         4'h7: cond_ok = ~v_f;
         4'h8: cond_ok = c_f & ~z_f;
         4'h9: cond_ok = ~c_f | z_f;
         4'ha: cond_ok = (n_f == v_f);
         4'hb: cond_ok = (n_f != v_f);
         4'hc: cond_ok = ~z_f & (n_f == v_f);
         4'hd: cond_ok = z_f | (n_f != v_f);
         4'he: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   logic [3:0] d_exe;
   logic       d_wb, d_mr, d_mw, d_bt, d_swe, op_ok;

   always_comb begin
      d_exe = 4'b0000;
      d_wb  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_bt  = 1'b0;
      op_ok = 1'b0;
      case (mode)
         2'b00: begin
            op_ok = 1'b1;
            d_wb  = 1'b1;
            case (opcode)
               4'b1101: d_exe = 4'b0001;
               4'b1111: d_exe = 4'b1001;
               4'b0100: d_exe = 4'b0010;
               4'b0101: d_exe = 4'b0011;
               4'b0010: d_exe = 4'b0100;
               4'b0110: d_exe = 4'b0101;
               4'b0000: d_exe = 4'b0110;
               4'b1100: d_exe = 4'b0111;
               4'b0001: d_exe = 4'b1000;
               4'b1010: begin d_exe = 4'b0100; d_wb = 1'b0; end
               4'b1000: begin d_exe = 4'b0110; d_wb = 1'b0; end
               default: begin op_ok = 1'b0; d_wb = 1'b0; end
            endcase
         end
         2'b01: begin
            d_exe = 4'b0010;
            d_mr  = s_bit;
            d_mw  = ~s_bit;
            d_wb  = s_bit;
         end
         2'b10: d_bt = 1'b1;
         default: ;
      endcase
   end

   assign d_swe = op_ok & s_bit;

   logic [DATA_W-1:0] rf [NREGS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NREGS; k++) rf[k] <= '0;
      end else if (wb_en && ({1'b0, wb_addr} < NR)) begin
         rf[wb_addr] <= wb_data;
      end
   end

   // Write-first: a same-cycle write-back is forwarded to the decode.
   logic [DATA_W-1:0] rd1, rd2;

   always_comb begin
      rd1 = '0;
      if (wb_en && (src1_addr == wb_addr)) rd1 = wb_data;
      else if ({1'b0, src1_addr} < NR) rd1 = rf[src1_addr];
   end

   always_comb begin
      rd2 = '0;
      if (wb_en && (src2_addr == wb_addr)) rd2 = wb_data;
      else if ({1'b0, src2_addr} < NR) rd2 = rf[src2_addr];
   end

   // A stall or flush injects a bubble; only a plain stall holds data.
   logic cap, load;
   assign cap  = ~(flush | stall) & in_valid & cond_ok;
   assign load = flush | ~stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_out     <= 1'b0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         wb_en_out     <= 1'b0;
         branch_taken  <= 1'b0;
         status_we     <= 1'b0;
         pc_out        <= '0;
         exe_cmd       <= '0;
         val_rn        <= '0;
         val_rm        <= '0;
         imm           <= 1'b0;
         shift_operand <= '0;
         signed_imm24  <= '0;
         dest          <= '0;
         status_out    <= '0;
      end else begin
         valid_out    <= cap;
         mem_read     <= cap & d_mr;
         mem_write    <= cap & d_mw;
         wb_en_out    <= cap & d_wb;
         branch_taken <= cap & d_bt;
         status_we    <= cap & d_swe;
         if (load) begin
            pc_out        <= pc_in;
            exe_cmd       <= d_exe;
            val_rn        <= rd1;
            val_rm        <= rd2;
            imm           <= i_bit;
            shift_operand <= instr_in[11:0];
            signed_imm24  <= instr_in[23:0];
            dest          <= AW'(rd);
            status_out    <= status;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_reg.sv
// Testbench for id_stage_reg: directed table, hand sequences for stall,
// flush and mid-stream reset, and random stimulus against a reference model.
module tb_id_stage_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_in = '0, instr_in = '0, wb_data = '0;
   logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0, wb_en = 1'b0;
   logic [3:0]  status = '0, wb_addr = '0;
   logic [3:0]  src1_addr, src2_addr, dest, exe_cmd, status_out;
   logic        two_src, valid_out, mem_read, mem_write, wb_en_out;
   logic        branch_taken, status_we, imm;
   logic [31:0] pc_out, val_rn, val_rm;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm24;

   always #5 clk = ~clk;

   id_stage_reg #(.DATA_W(32), .NREGS(16)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
      .in_valid(in_valid), .stall(stall), .flush(flush), .status(status),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .src1_addr(src1_addr), .src2_addr(src2_addr), .two_src(two_src),
      .pc_out(pc_out), .valid_out(valid_out), .mem_read(mem_read),
      .mem_write(mem_write), .wb_en_out(wb_en_out),
      .branch_taken(branch_taken), .status_we(status_we),
      .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
      .shift_operand(shift_operand), .signed_imm24(signed_imm24),
      .dest(dest), .status_out(status_out)
   );

   int nvec = 0;
   int nbad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic        v, mr, mw, wb, bt, swe;
      logic [3:0]  exe;
      logic [31:0] pc, rn, rm;
      logic        i;
      logic [11:0] sh;
      logic [23:0] si;
      logic [3:0]  dst, st;
   } ex_t;

   logic [31:0] mrf [16];
   ex_t         cur;
   logic [4:0]  opm [16];

   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] s);
      bit n, z, cy, v;
      {n, z, cy, v} = s;
      case (c)
         0: return z;
         1: return !z;
         2: return cy;
         3: return !cy;
         4: return n;
         5: return !n;
         6: return v;
         7: return !v;
         8: return cy && !z;
         9: return !cy || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] rdm(input logic [3:0] a);
      return (wb_en && a == wb_addr) ? wb_data : mrf[a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 16; k++) mrf[k] = '0;
      cur = '0;
   endtask

   task automatic cyc();
      ex_t nx;
      logic [1:0] md;
      logic [3:0] op, s2;
      logic s, st_op, g, ts;
      #1;
      md    = instr_in[27:26];
      op    = instr_in[24:21];
      s     = instr_in[20];
      st_op = (md == 1) && !s;
      s2    = st_op ? instr_in[15:12] : instr_in[3:0];
      ts    = in_valid && ((md == 0 && !instr_in[25]) || st_op);
      chk("src1_addr", src1_addr, instr_in[19:16]);
      chk("src2_addr", src2_addr, s2);
      chk("two_src", two_src, ts);
      nx = '0;
      if (stall && !flush) begin
         nx = cur;
         {nx.v, nx.mr, nx.mw, nx.wb, nx.bt, nx.swe} = '0;
      end else begin
         nx.pc  = pc_in;
         nx.rn  = rdm(instr_in[19:16]);
         nx.rm  = rdm(s2);
         nx.i   = instr_in[25];
         nx.sh  = instr_in[11:0];
         nx.si  = instr_in[23:0];
         nx.dst = instr_in[15:12];
         nx.st  = status;
         g = in_valid && cond_ok(instr_in[31:28], status) && !flush;
         nx.v = g;
         case (md)
            0: begin
               nx.exe = opm[op][3:0];
               if (opm[op][4]) begin
                  nx.wb  = g && !(op == 10 || op == 8);
                  nx.swe = g && s;
               end
            end
            1: begin
               nx.exe = 2;
               nx.mr  = g && s;
               nx.mw  = g && !s;
               nx.wb  = g && s;
            end
            2: nx.bt = g;
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      if (wb_en) mrf[wb_addr] = wb_data;
      cur = nx;
      chk("valid_out", valid_out, cur.v);
      chk("mem_read", mem_read, cur.mr);
      chk("mem_write", mem_write, cur.mw);
      chk("wb_en_out", wb_en_out, cur.wb);
      chk("branch_taken", branch_taken, cur.bt);
      chk("status_we", status_we, cur.swe);
      if (cur.v) chk("exe_cmd", exe_cmd, cur.exe);
      chk("pc_out", pc_out, cur.pc);
      chk("val_rn", val_rn, cur.rn);
      chk("val_rm", val_rm, cur.rm);
      chk("imm", imm, cur.i);
      chk("shift_operand", shift_operand, cur.sh);
      chk("signed_imm24", signed_imm24, cur.si);
      chk("dest", dest, cur.dst);
      chk("status_out", status_out, cur.st);
   endtask

   typedef struct packed {
      logic [31:0] ins;
      logic [3:0]  st;
      logic        iv, wbe;
      logic [3:0]  wba;
      logic [31:0] wbd;
      logic        v, mr, mw, wb, bt, swe;
      logic [3:0]  exe;
      logic [31:0] rn, rm;
   } vec_t;

   vec_t tbl [13];

   initial begin
      for (int k = 0; k < 16; k++) opm[k] = 5'b0_0000;
      opm[4'b1101] = 5'b1_0001;
      opm[4'b1111] = 5'b1_1001;
      opm[4'b0100] = 5'b1_0010;
      opm[4'b0101] = 5'b1_0011;
      opm[4'b0010] = 5'b1_0100;
      opm[4'b0110] = 5'b1_0101;
      opm[4'b0000] = 5'b1_0110;
      opm[4'b1100] = 5'b1_0111;
      opm[4'b0001] = 5'b1_1000;
      opm[4'b1010] = 5'b1_0100;
      opm[4'b1000] = 5'b1_0110;
      //            ins           st    iv wbe wba wbd     v mr mw wb bt swe exe rn     rm
      tbl[0]  = '{32'hE0821003, 4'h0, 0, 1, 2, 32'h05, 0, 0, 0, 0, 0, 0, 0, 32'h05, 32'h00};
      tbl[1]  = '{32'hE0821003, 4'h0, 0, 1, 3, 32'h07, 0, 0, 0, 0, 0, 0, 0, 32'h05, 32'h07};
      tbl[2]  = '{32'hE0821003, 4'h0, 1, 0, 0, 32'h00, 1, 0, 0, 1, 0, 0, 2, 32'h05, 32'h07};
      tbl[3]  = '{32'hE0821003, 4'h0, 1, 1, 2, 32'hAA, 1, 0, 0, 1, 0, 0, 2, 32'hAA, 32'h07};
      tbl[4]  = '{32'h0A000004, 4'h0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h00};
      tbl[5]  = '{32'h0A000004, 4'h4, 1, 0, 0, 32'h00, 1, 0, 0, 0, 1, 0, 0, 32'h00, 32'h00};
      tbl[6]  = '{32'hE5854000, 4'h0, 1, 1, 4, 32'h44, 1, 0, 1, 0, 0, 0, 2, 32'h00, 32'h44};
      tbl[7]  = '{32'hE5954000, 4'h0, 1, 0, 0, 32'h00, 1, 1, 0, 1, 0, 0, 2, 32'h00, 32'h00};
      tbl[8]  = '{32'hE1510002, 4'h0, 1, 0, 0, 32'h00, 1, 0, 0, 0, 0, 1, 4, 32'h00, 32'hAA};
      tbl[9]  = '{32'hE3A00005, 4'h0, 1, 0, 0, 32'h00, 1, 0, 0, 1, 0, 0, 1, 32'h00, 32'h00};
      tbl[10] = '{32'hE1710002, 4'h0, 1, 0, 0, 32'h00, 1, 0, 0, 0, 0, 0, 0, 32'h00, 32'hAA};
      tbl[11] = '{32'hF0821003, 4'h0, 1, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0, 32'hAA, 32'h07};
      tbl[12] = '{32'hE0821003, 4'h0, 0, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0, 32'hAA, 32'h07};

      model_reset();
      #3;
      chk("rst_valid", valid_out, 0);
      chk("rst_ctrl", {mem_read, mem_write, wb_en_out, branch_taken, status_we}, 0);
      chk("rst_exe", exe_cmd, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_ops", {val_rn, val_rm}, 0);
      chk("rst_fields", {imm, shift_operand, signed_imm24, dest, status_out}, 0);
      #9 rst = 1'b1;

      for (int k = 0; k < 13; k++) begin
         instr_in = tbl[k].ins;
         status   = tbl[k].st;
         in_valid = tbl[k].iv;
         wb_en    = tbl[k].wbe;
         wb_addr  = tbl[k].wba;
         wb_data  = tbl[k].wbd;
         pc_in    = 32'h100 + 32'(4 * k);
         stall    = 1'b0;
         flush    = 1'b0;
         cyc();
         chk("tbl_valid", valid_out, tbl[k].v);
         chk("tbl_ctrl", {mem_read, mem_write, wb_en_out, branch_taken, status_we},
             {tbl[k].mr, tbl[k].mw, tbl[k].wb, tbl[k].bt, tbl[k].swe});
         if (tbl[k].v) chk("tbl_exe", exe_cmd, tbl[k].exe);
         chk("tbl_rn", val_rn, tbl[k].rn);
         chk("tbl_rm", val_rm, tbl[k].rm);
      end
      chk("add_dest", dest, 1);

      // stall twice, then stall with flush
      wb_en = 0; in_valid = 1; status = 0;
      instr_in = 32'hE0821003; pc_in = 32'h200;
      cyc();
      instr_in = 32'hE5854000; pc_in = 32'h204; stall = 1;
      cyc();
      cyc();
      chk("stall_valid", valid_out, 0);
      chk("stall_rn_hold", val_rn, 32'hAA);
      chk("stall_dest_hold", dest, 1);
      chk("stall_pc_hold", pc_out, 32'h200);
      instr_in = 32'hE5954000; flush = 1;
      cyc();
      chk("flush_valid", valid_out, 0);
      chk("flush_ctrl", {mem_read, mem_write, wb_en_out}, 0);
      stall = 0; flush = 0;

      // asynchronous reset during a CMP stream
      instr_in = 32'hE1510002;
      cyc();
      cyc();
      chk("cmp_swe", status_we, 1);
      #2 rst = 1'b0;
      wb_en = 1; wb_addr = 2; wb_data = 32'h55;
      #1;
      chk("arst_swe", status_we, 0);
      chk("arst_valid", valid_out, 0);
      model_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      wb_en = 0; instr_in = '0; in_valid = 0;
      cyc();
      instr_in = 32'hE0821003; in_valid = 1;
      cyc();
      chk("arst_r2", val_rn, 0);

      for (int k = 0; k < 400; k++) begin
         logic [31:0] r;
         r = $urandom;
         if ($urandom_range(0, 3) != 0) r[31:28] = 4'hE;
         instr_in = r;
         pc_in    = $urandom;
         status   = 4'($urandom);
         in_valid = ($urandom_range(0, 9) != 0);
         stall    = ($urandom_range(0, 9) == 0);
         flush    = ($urandom_range(0, 11) == 0);
         wb_en    = $urandom_range(0, 1) == 1;
         wb_addr  = 4'($urandom);
         wb_data  = $urandom;
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/id_stage_reg.md
# id_stage_reg

Parametrised ARM decode stage with an integrated ID/EX pipeline register, an internal register file with same-cycle write-back bypass, condition evaluation against a live status input, and stall/flush control. It sits between the IF/ID register and the EX stage. It decodes one instruction per cycle into registered control, operand and immediate fields. It also exports combinational source addresses and a two-source flag to the hazard unit.

## Interface
- DATA_W, 32: register and PC width
- NREGS, 16: register count; address width AW = $clog2(NREGS), minimum 4
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- pc_in  in  DATA_W  PC of the instruction in ID
- instr_in  in  32  instruction word
- in_valid  in  1  the instruction in ID is real (not a bubble)
- stall  in  1  hazard unit: hold the ID/EX register, insert no new instruction
- flush  in  1  branch in EX: squash the instruction being captured
- status  in  4  {N,Z,C,V} from the status register
- wb_en  in  1  write-back enable
- wb_addr  in  AW  write-back register
- wb_data  in  DATA_W  write-back value
- src1_addr, src2_addr  out  AW  combinational source addresses for the hazard unit
- two_src  out  1  combinational; the instruction reads src2 (see Operation)
- pc_out  out  DATA_W  registered PC
- valid_out, mem_read, mem_write, wb_en_out, branch_taken, status_we  out  1 each  registered control
- exe_cmd  out  4  registered ALU command
- val_rn, val_rm  out  DATA_W  registered operands
- imm  out  1  registered I bit (instr[25])
- shift_operand  out  12  registered instr[11:0]
- signed_imm24  out  24  registered instr[23:0]
- dest  out  AW  registered Rd (instr[15:12])
- status_out  out  4  registered copy of status, used by EX for carry-in

## Operation
- Field extraction: cond=[31:28], mode=[27:26], I=[25], opcode=[24:21], S=[20], Rn=[19:16], Rd=[15:12], Rm=[3:0].
- Source addresses: src1 is Rn. src2 is Rd when the instruction is a store (mode 01, S=0); otherwise src2 is Rm. Both are zero-extended to AW.
- two_src = in_valid & ((mode==00 & ~I) | (mode==01 & ~S)).
- Mode 00, data processing:
  - exe_cmd mapping: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110. Any other opcode gives exe_cmd 0000 and all control bits 0.
  - wb_en is 1 except for CMP and TST. status_we = S.
- Mode 01, memory: exe_cmd=0010. S=1 is LDR (mem_read=1, wb_en=1). S=0 is STR (mem_write=1). status_we=0.
- Mode 10, branch: branch_taken=1, exe_cmd=0000, all other control bits 0.
- Mode 11: all control bits 0.
- Condition check uses status:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V)
  - AL 1; code 1111 evaluates 0.
- Register file: NREGS × DATA_W, written on the rising edge when wb_en is 1. Write to an address ≥ NREGS is ignored.
- Read bypass: a read of an address equal to wb_addr while wb_en is 1 returns wb_data in the same cycle (write-first).
- Capture rule at each rising edge, in priority order:
  1. flush=1: clear valid_out and all control bits. Data fields take don't-care values; implementation loads them normally. Flush wins over stall.
  2. stall=1: capture a bubble. valid_out and all control bits become 0; data fields are held. The upstream stage holds instr_in.
  3. Otherwise capture the decoded instruction. Control bits are gated by in_valid & cond_ok; when the gate is 0 they are forced to 0. valid_out = in_valid & cond_ok.

## Timing
- Reset (rst=0, asynchronous): every registered output is 0 and every register-file entry is 0. Outputs are 0 on the first edge after release.
- Latency: instr_in in cycle n appears on the registered outputs after edge n+1. Throughput is 1 per cycle.
- Combinational paths: src1_addr, src2_addr and two_src follow instr_in within the same cycle. So do val_rn and val_rm pre-register, including the bypass.
- A write-back in cycle n is visible to a decode in cycle n through the bypass, and to later decodes from the register file.
- Reset asserted mid-stream clears the pipeline register and the register file immediately. Any write-back in flight is lost.

## Test plan
- Reset, then decode ADD R1,R2,R3 (0xE0821003) with R2=5 and R3=7 preloaded through WB → next cycle: exe_cmd=0010, wb_en_out=1, val_rn=5, val_rm=7, dest=1, valid_out=1.
- Same-cycle bypass: wb_en=1, wb_addr=2, wb_data=0xAA while decoding a read of R2 → val_rn=0xAA after the edge.
- Condition check: BEQ (0x0A000004) with status Z=0 → branch_taken=0, valid_out=0. With Z=1 → branch_taken=1, signed_imm24=0x000004.
- STR R4,[R5] (0xE5854000) → mem_write=1, wb_en_out=0, src2_addr=4, two_src=1. LDR (0xE5954000) → mem_read=1, wb_en_out=1, two_src=0.
- Stall then flush: stall=1 for two cycles → valid_out=0 and data fields held. Raise stall and flush together → valid_out=0 and all control bits 0.
- Asynchronous reset during a stream of CMP (0xE1510002) with status_we=1 → status_we drops to 0 before the next edge, and R2 reads 0 afterwards.
